// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types, constants and helpers for the UART receive path
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_BREAK
  } rx_state_t;

  localparam int OVERSAMPLE = 16;

  // Vote window inside each oversampled bit; the last vote point is also the decision point.
  localparam logic [3:0] SAMPLE_FIRST = 4'd7;
  localparam logic [3:0] SAMPLE_LAST  = 4'd9;
  localparam logic [3:0] SAMPLE_WRAP  = 4'(OVERSAMPLE - 1);

  // Clock cycles per oversample tick, rounded to the nearest integer.
  function automatic int baud_div(input int frequency, input int bps);
    return (frequency + (OVERSAMPLE / 2) * bps) / (OVERSAMPLE * bps);
  endfunction

  function automatic logic majority3(input logic [2:0] v);
    return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
  endfunction

endpackage

// File: rtl/uart_rx_sampler_if.sv
// rtl/uart_rx_sampler_if.sv - received-byte output bundle of the UART receive front end
interface uart_rx_sampler_if;
  logic       valid;
  logic [7:0] q;
  logic       framing_error;
  logic       busy;

  modport master (
    output valid,
    output q,
    output framing_error,
    output busy
  );

  modport slave (
    input valid,
    input q,
    input framing_error,
    input busy
  );
endinterface

// File: rtl/uart_baud_tick.sv
// rtl/uart_baud_tick.sv - oversample tick generator, restartable so ticks align to the start edge
module uart_baud_tick #(
  parameter int DIV = 27
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] count;

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      count <= '0;
    end else if (count == LAST) begin
      count <= '0;
    end else begin
      count <= count + CW'(1);
    end
  end

  assign tick = (count == LAST);

endmodule

// File: rtl/uart_rx_sampler.sv
// rtl/uart_rx_sampler.sv - 8N1 receive front end: synchronizer, start detect, 16x majority-vote
// sampling, framing-error and line-break handling
module uart_rx_sampler
  import uart_pkg::*;
#(
  parameter int frequency = 50_000_000,
  parameter int bps       = 115_200
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              serial_in,
  uart_rx_sampler_if.master rx
);

  localparam int DIV = baud_div(frequency, bps);

  logic       sync_0;
  logic       rx_s;
  rx_state_t  state;
  rx_state_t  state_next;
  logic       tick;
  logic       clear;
  logic [3:0] s;
  logic [2:0] vote;
  logic [2:0] bit_count;
  logic [7:0] shift_reg;
  logic       bit_now;
  logic       at_vote;
  logic       at_decide;
  logic       at_wrap;
  logic       valid_d;
  logic       framing_error_d;

  always_ff @(posedge clock) begin
    if (reset) begin
      sync_0 <= 1'b1;
      rx_s   <= 1'b1;
    end else begin
      sync_0 <= serial_in;
      rx_s   <= sync_0;
    end
  end

  // Restarting the divider on the start edge puts every vote point at a fixed phase of the bit.
  assign clear = (state == ST_IDLE) && !rx_s;

  uart_baud_tick #(
    .DIV(DIV)
  ) u_baud_tick (
    .clock(clock),
    .reset(reset),
    .clear(clear),
    .tick (tick)
  );

  assign at_vote   = tick && (s >= SAMPLE_FIRST) && (s <= SAMPLE_LAST);
  assign at_decide = tick && (s == SAMPLE_LAST);
  assign at_wrap   = tick && (s == SAMPLE_WRAP);
  // The third vote is the sample being taken right now, so the decision needs no extra cycle.
  assign bit_now   = majority3({vote[1:0], rx_s});

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (!rx_s) begin
          state_next = ST_START;
        end
      end
      ST_START: begin
        if (at_decide && bit_now) begin
          state_next = ST_IDLE;
        end else if (at_wrap) begin
          state_next = ST_DATA;
        end
      end
      ST_DATA: begin
        if (at_wrap && (bit_count == 3'd7)) begin
          state_next = ST_STOP;
        end
      end
      ST_STOP: begin
        // Leave mid stop bit so a zero-gap next start edge is still caught.
        if (at_decide) begin
          state_next = bit_now ? ST_IDLE : ST_BREAK;
        end
      end
      ST_BREAK: begin
        if (rx_s) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    valid_d         = 1'b0;
    framing_error_d = 1'b0;
    if (state == ST_STOP && at_decide) begin
      valid_d         = bit_now;
      framing_error_d = !bit_now;
    end
  end

  always_ff @(posedge clock) begin
    if (reset || state == ST_IDLE) begin
      s         <= '0;
      bit_count <= '0;
    end else if (tick) begin
      s <= s + 4'd1;
      if (state == ST_DATA && s == SAMPLE_WRAP) begin
        bit_count <= bit_count + 3'd1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      vote      <= '0;
      shift_reg <= '0;
    end else begin
      if (at_vote) begin
        vote <= {vote[1:0], rx_s};
      end
      if (state == ST_DATA && at_decide) begin
        shift_reg <= {bit_now, shift_reg[7:1]};
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rx.valid         <= 1'b0;
      rx.framing_error <= 1'b0;
      rx.q             <= '0;
      rx.busy          <= 1'b0;
    end else begin
      rx.valid         <= valid_d;
      rx.framing_error <= framing_error_d;
      rx.busy          <= (state_next != ST_IDLE);
      if (valid_d || framing_error_d) begin
        rx.q <= shift_reg;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_sampler.sv
// tb/tb_uart_rx_sampler.sv - scoreboard bench for uart_rx_sampler with a bit-accurate line driver
module tb_uart_rx_sampler;

  localparam int BPS    = 115_200;
  localparam int FREQ   = 16 * 4 * BPS;
  localparam int BIT_T  = 640;
  localparam int FAST_T = 621;
  localparam int SLOW_T = 660;
  localparam int LAT    = 154 * 4 + 3;

  typedef struct packed {
    logic       ferr;
    logic [7:0] q;
  } exp_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic serial_in = 1'b1;

  uart_rx_sampler_if rx_if ();

  uart_rx_sampler #(
    .frequency(FREQ),
    .bps      (BPS)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .serial_in(serial_in),
    .rx       (rx_if.master)
  );

  always #5 clock = ~clock;

  exp_t       exp_q[$];
  exp_t       got;
  int         vectors = 0;
  int         miscompares = 0;
  int         cyc = 0;
  int         last_valid_cyc = -1;
  int         c0;
  logic       rst_seen = 1'b1;
  logic [7:0] q_prev = 8'h00;

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    if (rx_if.valid && rx_if.framing_error) begin
      vectors++;
      miscompares++;
      $display("FAIL exclusive: valid=1 framing_error=1, required at most one");
    end
    if (rx_if.valid || rx_if.framing_error) begin
      if (rx_if.valid) last_valid_cyc = cyc;
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_output: valid=%0b framing_error=%0b q=%02h, required no output",
                 rx_if.valid, rx_if.framing_error, rx_if.q);
      end else begin
        got = exp_q.pop_front();
        if (rx_if.framing_error !== got.ferr || rx_if.q !== got.q) begin
          miscompares++;
          $display("FAIL frame: framing_error=%0b q=%02h, required framing_error=%0b q=%02h",
                   rx_if.framing_error, rx_if.q, got.ferr, got.q);
        end
      end
    end else if (!rst_seen && rx_if.q !== q_prev) begin
      miscompares++;
      $display("FAIL q_hold: q=%02h, required %02h", rx_if.q, q_prev);
    end
    q_prev   = rx_if.q;
    rst_seen = reset;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop, input int bit_t);
    serial_in = 1'b0;
    #(bit_t);
    for (int i = 0; i < 8; i++) begin
      serial_in = d[i];
      #(bit_t);
    end
    serial_in = stop;
    #(bit_t);
  endtask

  task automatic expect_byte(input logic ferr, input logic [7:0] d);
    exp_t e;
    e.ferr = ferr;
    e.q    = d;
    exp_q.push_back(e);
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 2000 && exp_q.size() != 0; i++) @(negedge clock);
    check(name, exp_q.size(), 0);
  endtask

  initial begin
    repeat (4) @(posedge clock);
    #1;
    check("reset_state", {rx_if.valid, rx_if.framing_error, rx_if.busy, rx_if.q}, 0);
    reset = 1'b0;
    repeat (20) @(negedge clock);

    expect_byte(1'b0, 8'h55);
    send_frame(8'h55, 1'b1, BIT_T);
    #(2 * BIT_T);
    wait_drain("drain_55");
    check("busy_idle_55", rx_if.busy, 0);

    @(negedge clock);
    serial_in = 1'b0;
    repeat (10) @(negedge clock);
    check("busy_glitch_start", rx_if.busy, 1);
    repeat (2) @(negedge clock);
    serial_in = 1'b1;
    repeat (33) @(negedge clock);
    check("busy_glitch_rejected", rx_if.busy, 0);
    #(BIT_T);
    expect_byte(1'b0, 8'hA5);
    send_frame(8'hA5, 1'b1, BIT_T);
    #(2 * BIT_T);
    wait_drain("drain_a5");

    expect_byte(1'b1, 8'h00);
    send_frame(8'h00, 1'b0, BIT_T);
    #(40 * BIT_T);
    check("busy_in_break", rx_if.busy, 1);
    serial_in = 1'b1;
    repeat (10) @(negedge clock);
    check("busy_after_break", rx_if.busy, 0);
    expect_byte(1'b0, 8'h3C);
    send_frame(8'h3C, 1'b1, BIT_T);
    #(2 * BIT_T);
    wait_drain("drain_break");

    expect_byte(1'b0, 8'hA5);
    expect_byte(1'b0, 8'h3C);
    expect_byte(1'b0, 8'hFF);
    send_frame(8'hA5, 1'b1, FAST_T);
    send_frame(8'h3C, 1'b1, FAST_T);
    send_frame(8'hFF, 1'b1, FAST_T);
    #(2 * BIT_T);
    wait_drain("drain_fast");

    expect_byte(1'b0, 8'hA5);
    expect_byte(1'b0, 8'h3C);
    expect_byte(1'b0, 8'hFF);
    send_frame(8'hA5, 1'b1, SLOW_T);
    send_frame(8'h3C, 1'b1, SLOW_T);
    send_frame(8'hFF, 1'b1, SLOW_T);
    #(2 * BIT_T);
    wait_drain("drain_slow");

    serial_in = 1'b0;
    #(BIT_T);
    for (int i = 0; i < 5; i++) begin
      serial_in = (8'h12 >> i) & 8'h01;
      #(BIT_T);
    end
    serial_in = 1'b1;
    @(posedge clock);
    #1 reset = 1'b1;
    @(posedge clock);
    #1 reset = 1'b0;
    check("reset_mid_frame", {rx_if.valid, rx_if.framing_error, rx_if.busy, rx_if.q}, 0);
    #(4 * BIT_T);
    expect_byte(1'b0, 8'h34);
    send_frame(8'h34, 1'b1, BIT_T);
    #(2 * BIT_T);
    wait_drain("drain_34");

    expect_byte(1'b0, 8'h81);
    @(negedge clock);
    c0 = cyc;
    send_frame(8'h81, 1'b1, BIT_T);
    #(2 * BIT_T);
    wait_drain("drain_81");
    vectors++;
    if (last_valid_cyc - c0 < LAT - 1 || last_valid_cyc - c0 > LAT + 1) begin
      miscompares++;
      $display("FAIL latency_81: got %0d cycles, required %0d +/-1", last_valid_cyc - c0, LAT);
    end

    repeat (20) @(negedge clock);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
